// File: rtl/partialsum_output_collector.sv
// Receive end of the systolic array. In normal mode the 45-degree skewed
// column outputs are delayed into aligned rows and queued in a small FIFO that
// drains through a valid/ready handshake. In test mode the columns are compared
// in parallel against BIST golden values, building a sticky per-column fault map.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   test_mode              0: skewed capture into FIFO, 1: parallel compare
//   psum_valid_in          per-column valid from the array bottom
//   partial_sum_in_flat    column psums, column c at [c*PSW +: PSW]
//   expected_psum_flat     golden psums for test mode
//   compare_en             test mode: compare this cycle
//   fault_clear            synchronous clear of the fault map
//   psum_out_flat          aligned row at FIFO head
//   psum_out_valid         FIFO not empty
//   psum_out_ready         downstream accepts head row
//   fifo_full              FIFO holds FIFO_DEPTH rows
//   overflow_err           sticky: row dropped because FIFO was full
//   skew_err               sticky: de-skewed column valids disagreed
//   fault_column_out       sticky per-column mismatch map
//   compare_done           one-cycle pulse the cycle after a compare
module partialsum_output_collector #(
  parameter int unsigned SYSTOLIC_SIZE     = 8,
  parameter int unsigned WEIGHT_WIDTH      = 8,
  parameter int unsigned ACTIVATION_WIDTH  = 8,
  parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH
                                             + $clog2(SYSTOLIC_SIZE),
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   test_mode,
  input  logic [SYSTOLIC_SIZE-1:0]               psum_valid_in,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_in_flat,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] expected_psum_flat,
  input  logic                                   compare_en,
  input  logic                                   fault_clear,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] psum_out_flat,
  output logic                                   psum_out_valid,
  input  logic                                   psum_out_ready,
  output logic                                   fifo_full,
  output logic                                   overflow_err,
  output logic                                   skew_err,
  output logic [SYSTOLIC_SIZE-1:0]               fault_column_out,
  output logic                                   compare_done
);

  localparam int unsigned S   = SYSTOLIC_SIZE;
  localparam int unsigned PSW = PARTIAL_SUM_WIDTH;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  // ---------------------------------------------------------------------------
  // Mode edge detection: any change of test_mode flushes the delay lines.
  // ---------------------------------------------------------------------------
  logic test_mode_q;
  logic flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) test_mode_q <= 1'b0;
    else     test_mode_q <= test_mode;
  end

  assign flush = test_mode ^ test_mode_q;

  // ---------------------------------------------------------------------------
  // De-skew delay lines. Column c waits S-1-c cycles so every column of a row
  // lines up with the cycle the last column arrives.
  // ---------------------------------------------------------------------------
  logic [S-1:0]          col_valid;
  logic [S-1:0][PSW-1:0] col_data;
  logic [S-1:0]          aligned_valid;
  logic [S-1:0][PSW-1:0] aligned_data;

  // Valids are ignored in test mode so nothing enters the delay lines.
  assign col_valid = psum_valid_in & {S{~test_mode}};
  assign col_data  = partial_sum_in_flat;

  for (genvar c = 0; c < S; c++) begin : g_col
    localparam int unsigned Dly = S - 1 - c;
    if (Dly == 0) begin : g_direct
      assign aligned_valid[c] = col_valid[c];
      assign aligned_data[c]  = col_data[c];
    end else begin : g_dly
      logic [Dly-1:0]          v_q;
      logic [Dly-1:0][PSW-1:0] d_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          d_q <= '0;
        end else if (flush) begin
          v_q <= '0;
          d_q <= '0;
        end else begin
          v_q[0] <= col_valid[c];
          d_q[0] <= col_data[c];
          for (int unsigned k = 1; k < Dly; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end

      assign aligned_valid[c] = v_q[Dly-1];
      assign aligned_data[c]  = d_q[Dly-1];
    end
  end

  // During a flush cycle the undelayed last column is discarded as well.
  logic [S-1:0]       eff_valid;
  logic               row_push;
  logic [S*PSW-1:0]   row_flat;

  assign eff_valid = aligned_valid & {S{~flush}};
  assign row_push  = eff_valid[0];
  assign row_flat  = aligned_data;

  // ---------------------------------------------------------------------------
  // Aligned-row FIFO
  // ---------------------------------------------------------------------------
  logic [S*PSW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, pop, push;

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (count_q != '0) & psum_out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
  assign push = row_push & (~full | pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= row_flat;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign psum_out_flat  = mem_q[rd_ptr_q];
  assign psum_out_valid = (count_q != '0);
  assign fifo_full      = full;

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic overflow_q, skew_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (row_push & full & ~pop);
      skew_q     <= skew_q | (|(eff_valid ^ {S{row_push}}));
    end
  end

  assign overflow_err = overflow_q;
  assign skew_err     = skew_q;

  // ---------------------------------------------------------------------------
  // Test-mode compare and fault map
  // ---------------------------------------------------------------------------
  logic [S-1:0][PSW-1:0] exp_data;
  logic [S-1:0]          mism;
  logic                  cmp;
  logic [S-1:0]          fault_q, fault_d;
  logic                  done_q;

  assign exp_data = expected_psum_flat;
  assign cmp      = test_mode & compare_en;

  always_comb begin
    mism = '0;
    for (int unsigned c = 0; c < S; c++) mism[c] = (col_data[c] != exp_data[c]);
  end

  // Clear wins over a same-cycle compare.
  always_comb begin
    fault_d = fault_q | (cmp ? mism : '0);
    if (fault_clear) fault_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fault_q <= fault_d;
      done_q  <= cmp;
    end
  end

  assign fault_column_out = fault_q;
  assign compare_done     = done_q;

endmodule

// File: tb/tb_partialsum_output_collector.sv
module tb_partialsum_output_collector;

  localparam int S     = 8;
  localparam int PSW   = 19;
  localparam int DEPTH = 4;
  localparam int MAXC  = 1024;
  localparam int FW    = S * PSW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           test_mode = 1'b0;
  logic [S-1:0]   psum_valid_in = '0;
  logic [FW-1:0]  partial_sum_in_flat = '0;
  logic [FW-1:0]  expected_psum_flat = '0;
  logic           compare_en = 1'b0;
  logic           fault_clear = 1'b0;
  logic [FW-1:0]  psum_out_flat;
  logic           psum_out_valid;
  logic           psum_out_ready = 1'b0;
  logic           fifo_full;
  logic           overflow_err;
  logic           skew_err;
  logic [S-1:0]   fault_column_out;
  logic           compare_done;

  partialsum_output_collector #(
    .SYSTOLIC_SIZE    (S),
    .WEIGHT_WIDTH     (8),
    .ACTIVATION_WIDTH (8),
    .PARTIAL_SUM_WIDTH(PSW),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .test_mode          (test_mode),
    .psum_valid_in      (psum_valid_in),
    .partial_sum_in_flat(partial_sum_in_flat),
    .expected_psum_flat (expected_psum_flat),
    .compare_en         (compare_en),
    .fault_clear        (fault_clear),
    .psum_out_flat      (psum_out_flat),
    .psum_out_valid     (psum_out_valid),
    .psum_out_ready     (psum_out_ready),
    .fifo_full          (fifo_full),
    .overflow_err       (overflow_err),
    .skew_err           (skew_err),
    .fault_column_out   (fault_column_out),
    .compare_done       (compare_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus schedule: per absolute cycle, which columns are valid and their data.
  logic [S-1:0]   vin [MAXC];
  logic [PSW-1:0] din [MAXC][S];

  // Reference model state.
  logic [FW-1:0]  q[$];
  bit             ovf_m, skew_m, done_m;
  logic [S-1:0]   fault_m;
  int             cyc, base;
  bit             rdy;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Column c of the row whose column 0 arrived at cycle a; nothing before the
  // last reset release survives.
  function automatic logic col_v(int a, int c);
    if (a + c < base || a + c >= MAXC) return 1'b0;
    return vin[a + c][c];
  endfunction

  task automatic launch_row(input int t, input bit directed);
    for (int c = 0; c < S; c++) begin
      vin[t + c][c] = 1'b1;
      din[t + c][c] = directed ? PSW'(100 + c) : PSW'($urandom);
    end
  endtask

  // One normal-mode cycle; called and returns at a falling edge.
  task automatic norm_cycle();
    int          a;
    logic        push;
    logic [FW-1:0] row;
    bit          was_full, pop;
    check("out_valid", psum_out_valid, q.size() != 0);
    if (q.size() != 0) check("head_row", psum_out_flat, q[0]);
    check("fifo_full", fifo_full, q.size() == DEPTH);
    check("overflow_err", overflow_err, ovf_m);
    check("skew_err", skew_err, skew_m);
    psum_valid_in = vin[cyc];
    for (int c = 0; c < S; c++) partial_sum_in_flat[c*PSW +: PSW] = din[cyc][c];
    psum_out_ready = rdy;
    // A row is aligned S-1 cycles after its column 0 arrived.
    a    = cyc - (S - 1);
    push = col_v(a, 0);
    row  = '0;
    for (int c = 0; c < S; c++) begin
      if (col_v(a, c) != push) skew_m = 1'b1;
      if (a + c >= 0) row[c*PSW +: PSW] = din[a + c][c];
    end
    was_full = (q.size() == DEPTH);
    pop      = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!was_full || pop) q.push_back(row);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // One test-mode cycle; called and returns at a falling edge.
  task automatic tm_cycle(input logic [FW-1:0] in_v, input logic [FW-1:0] exp_v,
                          input bit ce, input bit fc);
    logic [S-1:0] mism;
    check("compare_done", compare_done, done_m);
    check("fault_map", fault_column_out, fault_m);
    check("tm_out_valid", psum_out_valid, 1'b0);
    psum_valid_in       = S'($urandom);
    partial_sum_in_flat = in_v;
    expected_psum_flat  = exp_v;
    compare_en          = ce;
    fault_clear         = fc;
    for (int c = 0; c < S; c++) mism[c] = (in_v[c*PSW +: PSW] != exp_v[c*PSW +: PSW]);
    done_m = ce;
    if (fc) fault_m = '0;
    else if (ce) fault_m = fault_m | mism;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_en  = 1'b0;
    fault_clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = cyc; k < MAXC; k++) vin[k] = '0;
    #1;
    check("rst_valid", psum_out_valid, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow_err, 1'b0);
    check("rst_skew", skew_err, 1'b0);
    check("rst_fault", fault_column_out, '0);
    check("rst_done", compare_done, 1'b0);
    check("rst_data", psum_out_flat, '0);
    psum_valid_in  = '0;
    psum_out_ready = 1'b0;
    test_mode      = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst    = 1'b0;
    base   = cyc;
    q.delete();
    ovf_m  = 1'b0;
    skew_m = 1'b0;
    done_m = 1'b0;
    fault_m = '0;
    rdy    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    logic [FW-1:0] exp_row, in_v, exp_v;

    for (int k = 0; k < MAXC; k++) begin
      vin[k] = '0;
      for (int c = 0; c < S; c++) din[k][c] = PSW'($urandom);
    end
    cyc = 0;
    base = 0;
    @(negedge clk);
    do_reset();

    // Skewed directed row: column c valid at relative cycle 10+c with 100+c.
    t = base + 10;
    launch_row(t, 1'b1);
    while (cyc < t + S) norm_cycle();
    for (int c = 0; c < S; c++) exp_row[c*PSW +: PSW] = PSW'(100 + c);
    check("row_valid_at_t+S", psum_out_valid, 1'b1);
    check("row_data", psum_out_flat, exp_row);
    check("row_skew", skew_err, 1'b0);
    rdy = 1'b1;
    repeat (3) norm_cycle();

    // Backpressure: five rows, ready low.
    do_reset();
    t = cyc + 2;
    for (int r = 0; r < 5; r++) launch_row(t + r, 1'b0);
    while (cyc < t + 4 + S + 1) norm_cycle();
    check("bp_full", fifo_full, 1'b1);
    check("bp_overflow", overflow_err, 1'b1);
    rdy = 1'b1;
    repeat (6) norm_cycle();
    check("bp_drained", psum_out_valid, 1'b0);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    t = cyc + 2;
    for (int r = 0; r < 4; r++) launch_row(t + r, 1'b0);
    launch_row(t + 6, 1'b0);
    while (cyc < t + 6 + S + 1) begin
      rdy = (cyc == t + 6 + S - 1);
      norm_cycle();
    end
    check("pp_no_overflow", overflow_err, 1'b0);
    check("pp_full", fifo_full, 1'b1);
    rdy = 1'b1;
    repeat (6) norm_cycle();

    // Skew fault: column 3 one cycle late.
    do_reset();
    t = cyc + 2;
    launch_row(t, 1'b0);
    vin[t + 3][3] = 1'b0;
    vin[t + 4][3] = 1'b1;
    din[t + 4][3] = din[t + 3][3];
    while (cyc < t + S) norm_cycle();
    check("skew_fault", skew_err, 1'b1);
    rdy = 1'b1;
    repeat (3) norm_cycle();

    // Randomized traffic with random ready.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 1) == 1) launch_row(cyc, 1'b0);
      rdy = ($urandom_range(0, 3) != 0);
      norm_cycle();
    end
    rdy = 1'b1;
    repeat (S + DEPTH + 2) norm_cycle();

    // Async reset three cycles into a row.
    do_reset();
    t = cyc + 1;
    launch_row(t, 1'b0);
    while (cyc < t + 3) norm_cycle();
    do_reset();
    repeat (S + 4) norm_cycle();

    // Test mode: directed compare, clear, clear-wins.
    test_mode = 1'b1;
    for (int c = 0; c < S; c++) begin
      exp_v[c*PSW +: PSW] = PSW'('h55);
      in_v[c*PSW +: PSW]  = (c == 5) ? PSW'('h54) : PSW'('h55);
    end
    tm_cycle(in_v, exp_v, 1'b0, 1'b0);
    tm_cycle(in_v, exp_v, 1'b1, 1'b0);
    check("tm_fault_col5", fault_column_out, 8'b0010_0000);
    check("tm_done_pulse", compare_done, 1'b1);
    tm_cycle(in_v, exp_v, 1'b0, 1'b0);
    tm_cycle(in_v, exp_v, 1'b0, 1'b1);
    check("tm_cleared", fault_column_out, '0);
    tm_cycle(in_v, exp_v, 1'b1, 1'b1);
    check("tm_clear_wins", fault_column_out, '0);

    // Test mode: randomized compares.
    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < S; c++) begin
        in_v[c*PSW +: PSW] = PSW'($urandom);
        exp_v[c*PSW +: PSW] = ($urandom_range(0, 1) == 1) ? in_v[c*PSW +: PSW]
                              : (in_v[c*PSW +: PSW] ^ (PSW'(1) << $urandom_range(0, PSW - 1)));
      end
      tm_cycle(in_v, exp_v, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    tm_cycle(in_v, exp_v, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
